// File: rtl/ccu_pkg.sv
// Shared cache-coherence definitions: line-address geometry and type, common to
// the conflict gate and the in-flight tracker.
package ccu_pkg;

  localparam int unsigned ADDR_WIDTH_DEF  = 48;
  localparam int unsigned LINE_OFFSET_DEF = 6;
  localparam int unsigned LINE_WIDTH_DEF  = ADDR_WIDTH_DEF - LINE_OFFSET_DEF;

  typedef logic [LINE_WIDTH_DEF-1:0] line_addr_t;

  function automatic line_addr_t line_of(input logic [ADDR_WIDTH_DEF-1:0] addr);
    return addr[ADDR_WIDTH_DEF-1:LINE_OFFSET_DEF];
  endfunction

endpackage

// File: rtl/ccu_conflict_gate_if.sv
// Bundle of the gate's request, tracker-lookup, tracker-push and issue ports.
// Handshakes: a transfer happens on a cycle where valid and ready are both high;
// a valid source holds its payload stable until that cycle.
interface ccu_conflict_gate_if #(
  parameter int ADDR_WIDTH  = ccu_pkg::ADDR_WIDTH_DEF,
  parameter int ID_WIDTH    = 4,
  parameter int LINE_OFFSET = ccu_pkg::LINE_OFFSET_DEF
);
  import ccu_pkg::*;

  logic                              req_valid_i;
  logic                              req_ready_o;
  logic [ADDR_WIDTH-1:0]             req_addr_i;
  logic [ID_WIDTH-1:0]               req_id_i;
  logic                              req_we_i;

  logic [ADDR_WIDTH-LINE_OFFSET-1:0] lookup_addr_o;
  logic                              lookup_match_i;

  logic                              trk_push_o;
  logic [ADDR_WIDTH-LINE_OFFSET-1:0] trk_data_o;
  logic                              trk_full_i;

  logic                              issue_valid_o;
  logic                              issue_ready_i;
  logic [ADDR_WIDTH-1:0]             issue_addr_o;
  logic [ID_WIDTH-1:0]               issue_id_o;
  logic                              issue_we_o;

  // master: the gate itself; slave: upstream, tracker and downstream around it
  modport master (
    input  req_valid_i, req_addr_i, req_id_i, req_we_i,
    input  lookup_match_i, trk_full_i, issue_ready_i,
    output req_ready_o, lookup_addr_o, trk_push_o, trk_data_o,
    output issue_valid_o, issue_addr_o, issue_id_o, issue_we_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_id_i, req_we_i,
    output lookup_match_i, trk_full_i, issue_ready_i,
    input  req_ready_o, lookup_addr_o, trk_push_o, trk_data_o,
    input  issue_valid_o, issue_addr_o, issue_id_o, issue_we_o
  );

endinterface

// File: rtl/ccu_conflict_gate.sv
// Holds one request, waits until its cache line is neither in flight nor the
// tracker full, records it in the tracker, then issues it downstream in order.
module ccu_conflict_gate
  import ccu_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int ID_WIDTH    = 4,
  parameter int LINE_OFFSET = LINE_OFFSET_DEF,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ccu_conflict_gate_if.master  bus,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic                 busy_o,
  output logic [1:0]           state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                            state_q;
  logic [ADDR_WIDTH-1:0]             addr_q;
  logic [ID_WIDTH-1:0]               id_q;
  logic                              we_q;
  logic [CNT_WIDTH-1:0]              cnt_q;
  logic [ADDR_WIDTH-LINE_OFFSET-1:0] line_q;
  logic                              in_check;
  logic                              blocked;
  logic                              accept;

  assign line_q   = addr_q[ADDR_WIDTH-1:LINE_OFFSET];
  assign in_check = (state_q == S_CHECK);
  // lookup_match_i already reflects this cycle's tracker contents; no pop bypass
  assign blocked  = bus.lookup_match_i || bus.trk_full_i;

  assign bus.req_ready_o   = (state_q == S_IDLE) || ((state_q == S_ISSUE) && bus.issue_ready_i);
  assign accept            = bus.req_valid_i && bus.req_ready_o;

  assign bus.lookup_addr_o = in_check ? line_q : '0;
  assign bus.trk_push_o    = in_check && !blocked;
  assign bus.trk_data_o    = line_q;

  assign bus.issue_valid_o = (state_q == S_ISSUE);
  assign bus.issue_addr_o  = addr_q;
  assign bus.issue_id_o    = id_q;
  assign bus.issue_we_o    = we_q;

  assign stall_cnt_o = cnt_q;
  assign busy_o      = (state_q != S_IDLE);
  assign state_dbg_o = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // Accept can only happen in IDLE or on the ISSUE handoff cycle, so the
      // holding register is never overwritten while still needed.
      if (accept) begin
        addr_q <= bus.req_addr_i;
        id_q   <= bus.req_id_i;
        we_q   <= bus.req_we_i;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (blocked) begin
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.issue_ready_i) state_q <= accept ? S_CHECK : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccu_conflict_gate.sv
// Bench for ccu_conflict_gate: directed scenarios plus a randomized phase, all
// checked against a transaction-level model of pending and issuable requests.
module tb_ccu_conflict_gate;
  import ccu_pkg::*;

  localparam int AW = 48;
  localparam int IW = 4;
  localparam int LO = 6;
  localparam int CW = 16;
  localparam int RW = AW + IW + 1;

  logic          clk;
  logic          rst;
  logic [CW-1:0] stall_cnt;
  logic          busy;
  logic [1:0]    state_dbg;

  ccu_conflict_gate_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .LINE_OFFSET(LO)) bus ();

  ccu_conflict_gate #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LINE_OFFSET(LO), .CNT_WIDTH(CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .stall_cnt_o (stall_cnt),
    .busy_o      (busy),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: accepted requests awaiting their tracker push, then awaiting issue
  logic [RW-1:0] pend_q[$];
  logic [RW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt;
  int            checks;
  int            errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] line_ext(input logic [RW-1:0] r);
    logic [AW-1:0] a;
    a = r[RW-1:IW+1];
    return 64'(line_of(a));
  endfunction

  task automatic settle();
    #1;
  endtask

  // One clock cycle: model-check all outputs against current inputs, advance
  // the model by the cycle's events, then step to the next negedge.
  task automatic tick();
    logic          blocked;
    logic          exp_ready;
    logic          exp_push;
    logic [RW-1:0] r;
    #1;
    blocked   = bus.lookup_match_i || bus.trk_full_i;
    exp_ready = (pend_q.size() == 0 && exp_q.size() == 0) ||
                (exp_q.size() != 0 && bus.issue_ready_i);
    exp_push  = (pend_q.size() != 0) && !blocked;
    if (!rst) begin
      chk("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
      chk("busy", 64'(busy), 64'((pend_q.size() + exp_q.size()) != 0));
      chk("trk_push", 64'(bus.trk_push_o), 64'(exp_push));
      chk("lookup_addr", 64'(bus.lookup_addr_o), (pend_q.size() != 0) ? line_ext(pend_q[0]) : 64'd0);
      if (exp_push) chk("trk_data", 64'(bus.trk_data_o), line_ext(pend_q[0]));
      chk("issue_valid", 64'(bus.issue_valid_o), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        r = exp_q[0];
        chk("issue_addr", 64'(bus.issue_addr_o), 64'(r[RW-1:IW+1]));
        chk("issue_id", 64'(bus.issue_id_o), 64'(r[IW:1]));
        chk("issue_we", 64'(bus.issue_we_o), 64'(r[0]));
      end
      chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
    end
    if (exp_q.size() != 0 && bus.issue_ready_i) void'(exp_q.pop_front());
    if (pend_q.size() != 0) begin
      if (blocked) begin
        if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      end else begin
        exp_q.push_back(pend_q.pop_front());
      end
    end
    if (bus.req_valid_i && exp_ready)
      pend_q.push_back({bus.req_addr_i, bus.req_id_i, bus.req_we_i});
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      exp_cnt = '0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic drive_idle();
    bus.req_valid_i    = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_id_i       = '0;
    bus.req_we_i       = 1'b0;
    bus.lookup_match_i = 1'b0;
    bus.trk_full_i     = 1'b0;
    bus.issue_ready_i  = 1'b1;
  endtask

  task automatic drive_req(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic we);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_id_i    = id;
    bus.req_we_i    = we;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = '0;
    rst     = 1'b1;
    drive_idle();
    @(negedge clk);
    do_reset();

    // reset state
    settle();
    chk("rst_ready", 64'(bus.req_ready_o), 64'd1);
    chk("rst_push", 64'(bus.trk_push_o), 64'd0);
    chk("rst_valid", 64'(bus.issue_valid_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lookup", 64'(bus.lookup_addr_o), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);

    // single request, minimum latency
    drive_req(48'h1000, 4'd3, 1'b0);
    tick();
    bus.req_valid_i = 1'b0;
    settle();
    chk("single_push", 64'(bus.trk_push_o), 64'd1);
    chk("single_data", 64'(bus.trk_data_o), 64'h40);
    chk("single_lookup", 64'(bus.lookup_addr_o), 64'h40);
    tick();
    settle();
    chk("single_valid", 64'(bus.issue_valid_o), 64'd1);
    chk("single_addr", 64'(bus.issue_addr_o), 64'h1000);
    chk("single_id", 64'(bus.issue_id_o), 64'd3);
    chk("single_cnt", 64'(stall_cnt), 64'd0);
    tick();
    settle();
    chk("single_done", 64'(busy), 64'd0);

    // match held 5 cycles
    do_reset();
    drive_req(48'h5000, 4'd5, 1'b0);
    bus.lookup_match_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("match_nopush", 64'(bus.trk_push_o), 64'd0);
      tick();
    end
    bus.lookup_match_i = 1'b0;
    settle();
    chk("match_push", 64'(bus.trk_push_o), 64'd1);
    chk("match_cnt", 64'(stall_cnt), 64'd5);
    tick();
    settle();
    chk("match_issue", 64'(bus.issue_valid_o), 64'd1);
    tick();

    // tracker full 3 cycles
    do_reset();
    drive_req(48'h7080, 4'd6, 1'b1);
    bus.trk_full_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("full_nopush", 64'(bus.trk_push_o), 64'd0);
      tick();
    end
    bus.trk_full_i = 1'b0;
    settle();
    chk("full_push", 64'(bus.trk_push_o), 64'd1);
    chk("full_cnt", 64'(stall_cnt), 64'd3);
    tick();
    tick();

    // back-to-back A then B
    do_reset();
    drive_req(48'h2000, 4'd1, 1'b0);
    tick();
    drive_req(48'h3040, 4'd2, 1'b0);
    settle();
    chk("b2b_a_push", 64'(bus.trk_data_o), 64'h80);
    chk("b2b_b_wait", 64'(bus.req_ready_o), 64'd0);
    tick();
    settle();
    chk("b2b_b_accept", 64'(bus.req_ready_o), 64'd1);
    chk("b2b_a_issue", 64'(bus.issue_addr_o), 64'h2000);
    tick();
    bus.req_valid_i = 1'b0;
    settle();
    chk("b2b_b_push", 64'(bus.trk_data_o), 64'hC1);
    chk("b2b_gap", 64'(bus.issue_valid_o), 64'd0);
    tick();
    settle();
    chk("b2b_b_issue", 64'(bus.issue_addr_o), 64'h3040);
    chk("b2b_b_id", 64'(bus.issue_id_o), 64'd2);
    tick();

    // downstream back-pressure for 4 cycles
    do_reset();
    drive_req(48'h4000, 4'd7, 1'b1);
    bus.issue_ready_i = 1'b0;
    tick();
    drive_req(48'h9000, 4'd9, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp_addr", 64'(bus.issue_addr_o), 64'h4000);
      chk("bp_id", 64'(bus.issue_id_o), 64'd7);
      chk("bp_we", 64'(bus.issue_we_o), 64'd1);
      chk("bp_ready", 64'(bus.req_ready_o), 64'd0);
      chk("bp_nopush", 64'(bus.trk_push_o), 64'd0);
      tick();
    end
    bus.issue_ready_i = 1'b1;
    settle();
    chk("bp_release", 64'(bus.req_ready_o), 64'd1);
    tick();
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // stall counter saturation, then reset while in CHECK
    do_reset();
    drive_req(48'h6000, 4'd4, 1'b0);
    bus.lookup_match_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 65538; i++) tick();
    settle();
    chk("sat_cnt", 64'(stall_cnt), 64'hFFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.lookup_match_i = 1'b0;
    settle();
    chk("rst_chk_busy", 64'(busy), 64'd0);
    chk("rst_chk_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_chk_push", 64'(bus.trk_push_o), 64'd0);
    chk("rst_chk_ready", 64'(bus.req_ready_o), 64'd1);
    tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.req_valid_i    = ($urandom_range(0, 2) != 0);
      bus.req_addr_i     = {16'($urandom), 32'($urandom)};
      bus.req_id_i       = 4'($urandom_range(0, 15));
      bus.req_we_i       = 1'($urandom_range(0, 1));
      bus.lookup_match_i = ($urandom_range(0, 3) == 0);
      bus.trk_full_i     = ($urandom_range(0, 5) == 0);
      bus.issue_ready_i  = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive_idle();
    for (int i = 0; i < 8; i++) tick();
    settle();
    chk("drain_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
